// File: rtl/dpram_rsp_checker_pkg.sv
// Shared types for the dual-port RAM response checker: word sizes, FSM states,
// the compare-slot record and the saturating counter helper.
package dpram_rsp_checker_pkg;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2,
      FAIL = 2'd3
   } state_t;

   typedef struct packed {
      logic              vld;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] exp;
   } slot_t;

   // Both ports can report in the same cycle, so the increment is 0..2.
   function automatic logic [7:0] sat_add8(input logic [7:0] cnt, input logic [1:0] inc);
      logic [8:0] sum;
      sum = {1'b0, cnt} + {7'd0, inc};
      return sum[8] ? 8'hFF : sum[7:0];
   endfunction

endpackage

// File: rtl/dpram_rsp_checker_chk_pipe.sv
// chk_pipe: one port's read-latency delay line; at the last stage the expected
// word is compared with the RAM output and a pass or err strobe is raised.
module chk_pipe
   import dpram_rsp_checker_pkg::*;
#(
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  slot_t             i_slot,
   input  logic [DATA_W-1:0] i_q,
   output logic              o_pass,
   output logic              o_err,
   output logic [ADDR_W-1:0] o_addr,
   output logic [DATA_W-1:0] o_exp
);

   logic [RD_LAT-1:0] r_vld;
   logic [ADDR_W-1:0] r_addr [RD_LAT];
   logic [DATA_W-1:0] r_exp  [RD_LAT];

   // Only the valid bits are reset; a flushed slot's payload is never looked at.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_vld <= '0;
      end else begin
         r_vld[0] <= i_slot.vld;
         for (int i = 1; i < RD_LAT; i++) r_vld[i] <= r_vld[i-1];
      end
   end

   always_ff @(posedge clk) begin
      r_addr[0] <= i_slot.addr;
      r_exp[0]  <= i_slot.exp;
      for (int i = 1; i < RD_LAT; i++) begin
         r_addr[i] <= r_addr[i-1];
         r_exp[i]  <= r_exp[i-1];
      end
   end

   assign o_addr = r_addr[RD_LAT-1];
   assign o_exp  = r_exp[RD_LAT-1];
   assign o_pass = r_vld[RD_LAT-1] && (i_q == r_exp[RD_LAT-1]);
   assign o_err  = r_vld[RD_LAT-1] && (i_q != r_exp[RD_LAT-1]);

endmodule

// File: rtl/dpram_rsp_checker.sv
// dpram_rsp_checker: shadows writes on both RAM ports and checks read data.
// Optional macro DPRAM_CHK_FREEZE_EN freezes counters and shadow once in FAIL.
module dpram_rsp_checker
   import dpram_rsp_checker_pkg::*;
#(
   parameter int RD_LAT     = 1,
   parameter int EXP_CHECKS = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] addr_a,
   input  logic [ADDR_W-1:0] addr_b,
   input  logic [DATA_W-1:0] data_a,
   input  logic [DATA_W-1:0] data_b,
   input  logic              we_a,
   input  logic              we_b,
   input  logic [DATA_W-1:0] q_a,
   input  logic [DATA_W-1:0] q_b,
   output logic [7:0]        pass_cnt,
   output logic [7:0]        err_cnt,
   output logic [7:0]        coll_cnt,
   output logic              fail,
   output logic              done,
   output logic              err_port,
   output logic [ADDR_W-1:0] err_addr,
   output logic [DATA_W-1:0] err_exp,
   output logic [DATA_W-1:0] err_got
);

   logic [DATA_W-1:0]    r_shadow [2**ADDR_W];
   logic [2**ADDR_W-1:0] r_valid;
   state_t               r_state, w_state_nxt;
   logic [7:0]           r_pass, r_err, r_coll;
   logic                 r_err_port;
   logic [ADDR_W-1:0]    r_err_addr;
   logic [DATA_W-1:0]    r_err_exp, r_err_got;

   logic                 w_same, w_wcoll, w_coll_a, w_coll_b, w_freeze, w_cap;
   slot_t                w_slot_a, w_slot_b;
   logic                 w_pass_a, w_err_a, w_pass_b, w_err_b;
   logic [ADDR_W-1:0]    w_addr_a, w_addr_b;
   logic [DATA_W-1:0]    w_exp_a, w_exp_b;
   logic [7:0]           w_pass_nxt, w_err_nxt, w_coll_nxt;

`ifdef DPRAM_CHK_FREEZE_EN
   assign w_freeze = (r_state == FAIL);
`else
   assign w_freeze = 1'b0;
`endif

   // A read racing a write on the other port to the same word has no defined result.
   assign w_same   = (addr_a == addr_b);
   assign w_wcoll  = we_a && we_b && w_same;
   assign w_coll_a = !we_a && we_b && w_same;
   assign w_coll_b = !we_b && we_a && w_same;

   always_comb begin
      w_slot_a.vld  = !we_a && !w_coll_a && r_valid[addr_a];
      w_slot_a.addr = addr_a;
      w_slot_a.exp  = r_shadow[addr_a];
      w_slot_b.vld  = !we_b && !w_coll_b && r_valid[addr_b];
      w_slot_b.addr = addr_b;
      w_slot_b.exp  = r_shadow[addr_b];
   end

   always_ff @(posedge clk) begin
      if (!w_freeze && !w_wcoll) begin
         if (we_a) r_shadow[addr_a] <= data_a;
         if (we_b) r_shadow[addr_b] <= data_b;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_valid <= '0;
      end else if (!w_freeze) begin
         if (w_wcoll) begin
            r_valid[addr_a] <= 1'b0;
         end else begin
            if (we_a) r_valid[addr_a] <= 1'b1;
            if (we_b) r_valid[addr_b] <= 1'b1;
         end
      end
   end

   chk_pipe #(.RD_LAT(RD_LAT)) u_pipe_a (
      .clk(clk), .rst(rst), .i_slot(w_slot_a), .i_q(q_a),
      .o_pass(w_pass_a), .o_err(w_err_a), .o_addr(w_addr_a), .o_exp(w_exp_a)
   );

   chk_pipe #(.RD_LAT(RD_LAT)) u_pipe_b (
      .clk(clk), .rst(rst), .i_slot(w_slot_b), .i_q(q_b),
      .o_pass(w_pass_b), .o_err(w_err_b), .o_addr(w_addr_b), .o_exp(w_exp_b)
   );

   assign w_pass_nxt = sat_add8(r_pass, {1'b0, w_pass_a} + {1'b0, w_pass_b});
   assign w_err_nxt  = sat_add8(r_err,  {1'b0, w_err_a}  + {1'b0, w_err_b});
   assign w_coll_nxt = sat_add8(r_coll, {1'b0, w_wcoll | w_coll_a | w_coll_b});

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pass <= '0;
         r_err  <= '0;
         r_coll <= '0;
      end else if (!w_freeze) begin
         r_pass <= w_pass_nxt;
         r_err  <= w_err_nxt;
         r_coll <= w_coll_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= IDLE;
      else      r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cap       = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_err_a || w_err_b) begin
               w_state_nxt = FAIL;
               w_cap       = 1'b1;
            end else if (we_a || we_b) begin
               w_state_nxt = RUN;
            end
         end
         RUN: begin
            if (w_err_a || w_err_b) begin
               w_state_nxt = FAIL;
               w_cap       = 1'b1;
            end else if (w_pass_nxt >= 8'(EXP_CHECKS) && r_err == 8'd0) begin
               w_state_nxt = DONE;
            end
         end
         DONE: begin
            if (w_err_a || w_err_b) begin
               w_state_nxt = FAIL;
               w_cap       = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Port A wins the first-error record when both ports miscompare together.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_err_port <= 1'b0;
         r_err_addr <= '0;
         r_err_exp  <= '0;
         r_err_got  <= '0;
      end else if (w_cap) begin
         r_err_port <= !w_err_a;
         r_err_addr <= w_err_a ? w_addr_a : w_addr_b;
         r_err_exp  <= w_err_a ? w_exp_a  : w_exp_b;
         r_err_got  <= w_err_a ? q_a      : q_b;
      end
   end

   assign pass_cnt = r_pass;
   assign err_cnt  = r_err;
   assign coll_cnt = r_coll;
   assign fail     = (r_state == FAIL);
   assign done     = (r_state == DONE);
   assign err_port = r_err_port;
   assign err_addr = r_err_addr;
   assign err_exp  = r_err_exp;
   assign err_got  = r_err_got;

endmodule

// File: tb/tb_dpram_rsp_checker.sv
// Bench for dpram_rsp_checker: behavioural RAM, queue-based reference model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_dpram_rsp_checker;
   import dpram_rsp_checker_pkg::*;

   localparam int RD_LAT     = 1;
   localparam int EXP_CHECKS = 16;
`ifdef DPRAM_CHK_FREEZE_EN
   localparam bit FREEZE_MODEL = 1'b1;
`else
   localparam bit FREEZE_MODEL = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic [ADDR_W-1:0] addr_a = '0, addr_b = '0;
   logic [DATA_W-1:0] data_a = '0, data_b = '0;
   logic              we_a = 1'b0, we_b = 1'b0;
   logic [DATA_W-1:0] q_a, q_b;
   logic [7:0]        pass_cnt, err_cnt, coll_cnt;
   logic              fail, done, err_port;
   logic [ADDR_W-1:0] err_addr;
   logic [DATA_W-1:0] err_exp, err_got;

   dpram_rsp_checker #(.RD_LAT(RD_LAT), .EXP_CHECKS(EXP_CHECKS)) dut (
      .clk(clk), .rst(rst),
      .addr_a(addr_a), .addr_b(addr_b), .data_a(data_a), .data_b(data_b),
      .we_a(we_a), .we_b(we_b), .q_a(q_a), .q_b(q_b),
      .pass_cnt(pass_cnt), .err_cnt(err_cnt), .coll_cnt(coll_cnt),
      .fail(fail), .done(done), .err_port(err_port), .err_addr(err_addr),
      .err_exp(err_exp), .err_got(err_got)
   );

   always #5 clk = ~clk;

   // Behavioural RAM with one cycle of read latency, read-before-write.
   logic [DATA_W-1:0] ram [2**ADDR_W];
   logic [DATA_W-1:0] r_qa = '0, r_qb = '0;
   logic              force_a = 1'b0;
   logic [DATA_W-1:0] force_val = '0;

   always @(posedge clk) begin
      if (we_a) ram[addr_a] <= data_a;
      if (we_b) ram[addr_b] <= data_b;
      r_qa <= ram[addr_a];
      r_qb <= ram[addr_b];
   end
   assign q_a = force_a ? force_val : r_qa;
   assign q_b = r_qb;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string nm, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, got, exp, $time);
      end
   endtask

   // Reference model: dictionary of written words plus a queue of pending reads.
   typedef struct {
      int due;
      bit port;
      int addr;
      int exp;
   } pend_t;

   pend_t pq[$];
   pend_t p;
   int    m_shadow[int];
   int    m_pass, m_err, m_coll, m_eport, m_eaddr, m_eexp, m_egot;
   bit    m_started, m_done, m_fail;
   int    cyc, npass, nerr, ncoll, got;
   bit    fa, fb, frz;
   int    ea_addr, ea_exp, ea_got, eb_addr, eb_exp, eb_got;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         pq.delete();
         m_shadow.delete();
         m_pass = 0; m_err = 0; m_coll = 0;
         m_eport = 0; m_eaddr = 0; m_eexp = 0; m_egot = 0;
         m_started = 0; m_done = 0; m_fail = 0;
      end else begin
         cyc++;
         npass = 0; nerr = 0; ncoll = 0; fa = 0; fb = 0;
         while (pq.size() > 0 && pq[0].due == cyc) begin
            p   = pq.pop_front();
            got = p.port ? int'(q_b) : int'(q_a);
            if (got == p.exp) npass++;
            else begin
               nerr++;
               if (!p.port) begin fa = 1; ea_addr = p.addr; ea_exp = p.exp; ea_got = got; end
               else         begin fb = 1; eb_addr = p.addr; eb_exp = p.exp; eb_got = got; end
            end
         end
         frz = m_fail && FREEZE_MODEL;
         if (!we_a) begin
            if (we_b && addr_b == addr_a) ncoll++;
            else if (m_shadow.exists(int'(addr_a)))
               pq.push_back('{cyc + RD_LAT, 1'b0, int'(addr_a), m_shadow[int'(addr_a)]});
         end
         if (!we_b) begin
            if (we_a && addr_a == addr_b) ncoll++;
            else if (m_shadow.exists(int'(addr_b)))
               pq.push_back('{cyc + RD_LAT, 1'b1, int'(addr_b), m_shadow[int'(addr_b)]});
         end
         if (we_a && we_b && addr_a == addr_b) begin
            ncoll++;
            if (!frz) m_shadow.delete(int'(addr_a));
         end else if (!frz) begin
            if (we_a) m_shadow[int'(addr_a)] = int'(data_a);
            if (we_b) m_shadow[int'(addr_b)] = int'(data_b);
         end
         if (!frz) begin
            m_pass = (m_pass + npass > 255) ? 255 : m_pass + npass;
            m_err  = (m_err + nerr > 255)   ? 255 : m_err + nerr;
            m_coll = (m_coll + ncoll > 255) ? 255 : m_coll + ncoll;
         end
         if (!m_fail) begin
            if (fa || fb) begin
               m_fail = 1; m_done = 0;
               m_eport = fa ? 0 : 1;
               m_eaddr = fa ? ea_addr : eb_addr;
               m_eexp  = fa ? ea_exp  : eb_exp;
               m_egot  = fa ? ea_got  : eb_got;
            end else if (!m_started) begin
               m_started = we_a || we_b;
            end else if (!m_done && m_pass >= EXP_CHECKS && m_err == 0) begin
               m_done = 1;
            end
         end
      end
   end

   always @(negedge clk) begin
      chk("pass_cnt", int'(pass_cnt), m_pass);
      chk("err_cnt",  int'(err_cnt),  m_err);
      chk("coll_cnt", int'(coll_cnt), m_coll);
      chk("fail",     int'(fail),     int'(m_fail));
      chk("done",     int'(done),     int'(m_done));
      chk("err_port", int'(err_port), m_eport);
      chk("err_addr", int'(err_addr), m_eaddr);
      chk("err_exp",  int'(err_exp),  m_eexp);
      chk("err_got",  int'(err_got),  m_egot);
   end

   task automatic step(input bit wa, input int aa, input int da,
                       input bit wb, input int ab, input int db);
      @(negedge clk);
      we_a = wa; addr_a = ADDR_W'(aa); data_a = DATA_W'(da);
      we_b = wb; addr_b = ADDR_W'(ab); data_b = DATA_W'(db);
   endtask

   task automatic park();
      step(0, 500, 0, 0, 501, 0);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_pass"}, int'(pass_cnt), 0);
      chk({tag, "_err"},  int'(err_cnt),  0);
      chk({tag, "_coll"}, int'(coll_cnt), 0);
      chk({tag, "_fail"}, int'(fail),     0);
      chk({tag, "_done"}, int'(done),     0);
      chk({tag, "_eaddr"}, int'(err_addr), 0);
      chk({tag, "_egot"}, int'(err_got),  0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 rst = 1'b0;
      force_a = 1'b0;
      we_a = 0; we_b = 0; addr_a = 10'd500; addr_b = 10'd501;
      @(negedge clk);
      #1 chk_zero("rst");
      #1 rst = 1'b1;
   endtask

   initial begin
      we_a = 0; we_b = 0; addr_a = 10'd500; addr_b = 10'd501;
      repeat (2) @(negedge clk);
      #1 chk_zero("init");
      #1 rst = 1'b1;

      // Basic write then read on both ports, extreme addresses.
      step(1, 0, 1, 1, 1023, 2);
      step(0, 0, 0, 0, 1023, 0);
      park(); park();
      #1 chk("t1_pass", int'(pass_cnt), 2);
      chk("t1_err",  int'(err_cnt), 0);
      chk("t1_fail", int'(fail), 0);

      // Sixteen checks reach DONE on the last result.
      do_reset();
      for (int i = 0; i < 8; i++)
         step(1, (i == 7) ? 720 : 700 + i, (i == 7) ? 10 : 100 + i,
              1, (i == 7) ? 20 : 10 + i,   (i == 7) ? 5 : 200 + i);
      for (int i = 0; i < 8; i++)
         step(0, (i == 7) ? 720 : 700 + i, 0, 0, (i == 7) ? 20 : 10 + i, 0);
      park();
      #1 chk("t2_pass14", int'(pass_cnt), 14);
      chk("t2_done_early", int'(done), 0);
      park();
      #1 chk("t2_pass16", int'(pass_cnt), 16);
      chk("t2_done", int'(done), 1);
      park(); park();
      #1 chk("t2_done_hold", int'(done), 1);

      // Forced miscompare on port A.
      do_reset();
      step(1, 1, 3, 0, 501, 0);
      step(0, 1, 0, 0, 501, 0);
      force_val = 16'd7; force_a = 1'b1;
      park(); park();
      force_a = 1'b0;
      #1 chk("t3_fail", int'(fail), 1);
      chk("t3_eport", int'(err_port), 0);
      chk("t3_eaddr", int'(err_addr), 1);
      chk("t3_eexp",  int'(err_exp), 3);
      chk("t3_egot",  int'(err_got), 7);
      chk("t3_err",   int'(err_cnt), 1);
      chk("t3_pass",  int'(pass_cnt), 0);
      chk("t3_done",  int'(done), 0);

      // Reads of never-written words do nothing.
      do_reset();
      step(1, 3, 4, 0, 501, 0);
      step(0, 3, 0, 0, 501, 0);
      park(); park();
      #1 chk("t4_pass_pre", int'(pass_cnt), 1);
      repeat (3) step(0, 500, 0, 0, 500, 0);
      park(); park();
      #1 chk("t4_pass", int'(pass_cnt), 1);
      chk("t4_coll", int'(coll_cnt), 0);
      chk("t4_err",  int'(err_cnt), 0);

      // Write/write and read/write collisions.
      do_reset();
      step(1, 2, 5, 1, 2, 9);
      step(1, 4, 6, 0, 501, 0);
      step(0, 2, 0, 0, 2, 0);
      step(1, 4, 8, 0, 4, 0);
      step(0, 4, 0, 0, 501, 0);
      park(); park();
      #1 chk("t5_coll", int'(coll_cnt), 2);
      chk("t5_pass", int'(pass_cnt), 1);
      chk("t5_err",  int'(err_cnt), 0);

      // Reset pulse between read issue and its result.
      step(1, 6, 11, 0, 501, 0);
      step(0, 6, 0, 0, 501, 0);
      @(posedge clk);
      #2 rst = 1'b0;
      #1 chk_zero("t6_async");
      #1 rst = 1'b1;
      park(); park(); park();
      #1 chk("t6_pass", int'(pass_cnt), 0);
      chk("t6_err",  int'(err_cnt), 0);
      chk("t6_fail", int'(fail), 0);
      chk("t6_done", int'(done), 0);

      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
